// File: rtl/bcd_convp.sv
// Binary-to-ASCII-decimal converter: shift-add-3 engine (one bit per clock), then
// MSB-first digit streaming. Define BCD_CONVP_LZS_EN for leading-zero suppression.
module bcd_convp #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bin_req_pls,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             next_quotient_pls,
  output logic [7:0]       dec_out,
  output logic             dec_valid,
  output logic             dec_last,
  output logic             busy,
  output logic             overflow,
  output logic             req_drop_pls,
  output logic [1:0]       state_dbg
);

  // Handshake: a digit is presented while dec_valid=1; a next_quotient_pls seen
  // with dec_valid=1 consumes it and the following digit appears after that edge.

  localparam int BCD_W = 4 * DIGITS;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef BCD_CONVP_LZS_EN
  localparam bit LZS_EN = 1'b1;
`else
  localparam bit LZS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, OUT = 2'd2} state_t;

  state_t           state;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_adj;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;

  assign state_dbg = state;

  // Per-nibble +3 correction; each nibble is adjusted independently, no carries.
  always_comb begin
    bcd_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      bcd_adj[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
    end
  end

  function automatic logic [7:0] digit_char(input logic [BCD_W-1:0] b,
                                            input logic [IW-1:0]    i,
                                            input logic             ovf);
    logic [3:0] nib;
    logic       lz;
    nib = b[4*i +: 4];
    lz  = 1'b1;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      if (j >= int'(i) && b[4*j +: 4] != 4'd0) lz = 1'b0;
    end
    // The least significant digit is always a numeral; overflow disables blanking.
    if (LZS_EN && lz && (i != '0) && !ovf) return 8'h20;
    return 8'h30 + {4'h0, nib};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bin_sr       <= '0;
      bcd          <= '0;
      cnt          <= '0;
      idx          <= '0;
      dec_out      <= 8'h00;
      dec_valid    <= 1'b0;
      dec_last     <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      req_drop_pls <= 1'b0;
    end else begin
      req_drop_pls <= bin_req_pls && (state != IDLE);
      case (state)
        IDLE: begin
          if (bin_req_pls) begin
            bin_sr   <= bin_in;
            bcd      <= '0;
            overflow <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          if (cnt == CW'(BIN_W)) begin
            state     <= OUT;
            idx       <= IW'(DIGITS - 1);
            dec_out   <= digit_char(bcd, IW'(DIGITS - 1), overflow);
            dec_valid <= 1'b1;
            dec_last  <= (DIGITS == 1);
          end else begin
            bcd    <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
            bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
            if (bcd_adj[BCD_W-1]) overflow <= 1'b1;
            cnt    <= cnt + 1'b1;
          end
        end
        OUT: begin
          if (next_quotient_pls && dec_valid) begin
            if (dec_last) begin
              state     <= IDLE;
              dec_valid <= 1'b0;
              dec_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              idx      <= idx - 1'b1;
              dec_out  <= digit_char(bcd, idx - 1'b1, overflow);
              dec_last <= (idx == IW'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convp.sv
// Directed bench for bcd_convp (BIN_W=27, DIGITS=8): driver issues requests and
// consume pulses, a negedge monitor pops expected digits from a queue and compares.
module tb_bcd_convp;
  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             bin_req_pls = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic             next_quotient_pls = 1'b0;
  logic [7:0]       dec_out;
  logic             dec_valid, dec_last, busy, overflow, req_drop_pls;
  logic [1:0]       state_dbg;

  logic [9:0] exp_q[$];   // {overflow, last, char}
  int errors = 0;
  int checks = 0;

  bcd_convp #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset_n(reset_n), .bin_req_pls(bin_req_pls), .bin_in(bin_in),
    .next_quotient_pls(next_quotient_pls), .dec_out(dec_out), .dec_valid(dec_valid),
    .dec_last(dec_last), .busy(busy), .overflow(overflow), .req_drop_pls(req_drop_pls),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: a digit is consumed when the pulse meets dec_valid
  always @(negedge clk) begin
    if (reset_n && dec_valid && next_quotient_pls) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL digit_unexpected: got 0x%0h with empty expected queue", dec_out);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({overflow, dec_last, dec_out} !== e) begin
          errors++;
          $display("FAIL digit: got ovf=%0b last=%0b char=0x%0h expected ovf=%0b last=%0b char=0x%0h",
                   overflow, dec_last, dec_out, e[9], e[8], e[7:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic push_str(input string s, input bit ovf);
    for (int i = 0; i < DIGITS; i++) exp_q.push_back({ovf, (i == DIGITS - 1), s[i]});
  endtask

  // drop_mode: 0 none, 1 extra request during CONV, 2 during OUT, 3 with final step
  task automatic run_req(input logic [BIN_W-1:0] v, input int drop_mode, input int n_consume);
    int cycles;
    @(posedge clk); #1;
    bin_in = v; bin_req_pls = 1'b1;
    @(posedge clk); #1;
    bin_req_pls = 1'b0;
    check("busy_after_req", busy, 1);
    cycles = 0;
    while (!dec_valid && cycles < 200) begin
      if (drop_mode == 1 && cycles == 5) begin
        bin_in = BIN_W'($urandom_range(0, 1000)); bin_req_pls = 1'b1;
      end
      @(posedge clk); #1;
      if (drop_mode == 1 && cycles == 5) begin
        bin_req_pls = 1'b0;
        check("drop_in_conv", req_drop_pls, 1);
      end
      cycles++;
    end
    check("latency", cycles, BIN_W + 1);
    if (drop_mode == 2) begin
      bin_in = BIN_W'($urandom_range(0, 1000)); bin_req_pls = 1'b1;
      @(posedge clk); #1;
      bin_req_pls = 1'b0;
      check("drop_in_out", req_drop_pls, 1);
      check("valid_after_drop", dec_valid, 1);
    end
    for (int i = 0; i < n_consume; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      next_quotient_pls = 1'b1;
      if (drop_mode == 3 && i == DIGITS - 1) bin_req_pls = 1'b1;
      @(posedge clk); #1;
      next_quotient_pls = 1'b0;
      if (drop_mode == 3 && i == DIGITS - 1) begin
        bin_req_pls = 1'b0;
        check("drop_on_final", req_drop_pls, 1);
      end
    end
  endtask

  task automatic check_done(input logic [7:0] last_char);
    check("valid_low_done", dec_valid, 0);
    check("last_low_done", dec_last, 0);
    check("busy_low_done", busy, 0);
    check("dec_out_hold", dec_out, last_char);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_dec_out", dec_out, 0);
    check("rst_flags", {dec_valid, dec_last, busy, overflow, req_drop_pls}, 0);
    check("rst_state", state_dbg, 0);
    reset_n = 1'b1;

    push_str("91234567", 1'b0);
    run_req(27'd91234567, 0, DIGITS);
    check_done(8'h37);

`ifdef BCD_CONVP_LZS_EN
    push_str("       0", 1'b0);
`else
    push_str("00000000", 1'b0);
`endif
    run_req(27'd0, 0, DIGITS);
    check_done(8'h30);

    push_str("34217727", 1'b1);
    run_req(27'h7FFFFFF, 0, DIGITS);
    check_done(8'h37);

    push_str("00000000", 1'b1);
    run_req(27'd100000000, 0, DIGITS);
    check_done(8'h30);

`ifdef BCD_CONVP_LZS_EN
    push_str("    1234", 1'b0);
`else
    push_str("00001234", 1'b0);
`endif
    run_req(27'd1234, 1, DIGITS);
    check_done(8'h34);

    push_str("10000005", 1'b0);
    run_req(27'd10000005, 2, DIGITS);
    check_done(8'h35);

    push_str("99999999", 1'b0);
    run_req(27'd99999999, 3, DIGITS);
    check_done(8'h39);
    @(posedge clk); #1;
    check("idle_after_drop_final", state_dbg, 0);

    // reset mid-OUT after three digits
    push_str("91234567", 1'b0);
    run_req(27'd91234567, 0, 3);
    reset_n = 1'b0;
    #1;
    check("midrst_dec_out", dec_out, 0);
    check("midrst_flags", {dec_valid, dec_last, busy, overflow, req_drop_pls}, 0);
    check("midrst_state", state_dbg, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;

    push_str("87654321", 1'b0);
    run_req(27'd87654321, 0, DIGITS);
    check_done(8'h31);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
